encrypt_ctrl: RTL
=================

Name: encrypt_ctrl

Overview:
- Iterative sequencer for the byte cipher: XOR key, bit permutation, XOR key, bit permutation, XOR key.
- Executes one round per clock.
- Handles encrypt and decrypt.
- Owns the active key/permutation set, with an optional runtime configuration port.
- Sits between the byte source and sink in the encrypt/decrypt top.

Parameters:
KEY1_RST, `XOR_KEY1 (8'hDE), reset/default value of key 1
KEY2_RST, `XOR_KEY2 (8'hAD), reset/default value of key 2
KEY3_RST, `XOR_KEY3 (8'hBE), reset/default value of key 3

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input byte valid
in_ready  out  1  controller can accept a byte
in_data  in  8  plaintext (encrypt) or ciphertext (decrypt)
in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with in_data
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_data  out  8  result byte
busy  out  1  high whenever state != IDLE
cfg_wr  in  1  config write strobe
cfg_addr  in  4  0-7 = perm entry i (wdata[2:0]); 8/9/10 = key1/2/3; 11-15 ignored
cfg_wdata  in  8  config write data
cfg_commit  in  1  copy shadow config to active
cfg_err  out  1  last commit rejected (sticky)

Behaviour:
- Permutation semantics:
  - P: out[i] = in[perm[i]].
  - Pinv: out[perm[i]] = in[i].
  - Default perm[i] = `PERM_i, i.e. bit reversal.
- Encrypt: c = P(P(d^K1)^K2)^K3.
- Decrypt rounds (inverse of encrypt):
  - R0: acc = Pinv(acc^K3)
  - R1: acc = Pinv(acc^K2)
  - R2: acc = acc^K1
- Encrypt rounds:
  - R0: acc = P(acc^K1)
  - R1: acc = P(acc^K2)
  - R2: acc = acc^K3
- States:
  - IDLE: in_ready=1. On in_valid: acc<=in_data, mode<=in_decrypt, rnd<=0, go to RUN.
  - RUN: apply round rnd; rnd increments. After R2, go to DONE.
  - DONE: out_valid=1, out_data=acc held stable. On out_ready, go to IDLE.
- Latency:
  - Accept at edge n; out_valid high after edge n+3.
  - Minimum 5 cycles per byte with out_ready tied high.
- Stalls and stability:
  - No new accept while not IDLE (in_ready=0).
  - in_data and in_decrypt are ignored outside IDLE.
  - mode and key set are frozen for the whole operation.
- Reset values (any cycle, including mid-RUN/DONE): state IDLE, acc 0, rnd 0, out_valid 0, out_data 8'h00, busy 0, cfg_err 0. Shadow and active config return to defaults. In-flight byte is discarded.
- Config (feature enabled):
  - cfg_wr writes the shadow set in any state.
  - cfg_commit acts only in IDLE and only when in_valid is not accepted that cycle; it is ignored otherwise.
  - Commit with shadow perm a bijection (each index 0-7 exactly once): active<=shadow, cfg_err<=0. The new set applies from the next accepted byte.
  - Commit with shadow perm not a bijection: active unchanged, cfg_err<=1.
  - cfg_wr and cfg_commit in the same cycle: the write lands in shadow first and the commit uses the updated shadow.
  - Unmapped addresses have no effect.

Optional Feature:
ENCRYPT_CFG_EN
- Defined: runtime configuration as described above.
- Undefined:
  - cfg_wr, cfg_addr, cfg_wdata and cfg_commit are present but ignored.
  - cfg_err is tied 0.
  - Active set is constant: KEY1_RST..KEY3_RST and `PERM_0..`PERM_7.
  - No shadow registers are synthesised.

Test Plan:
- Encrypt default config, in_data 8'h00 -> out_data 8'hD5, out_valid 3 cycles after accept. in_data 8'hFF -> 8'h2A.
- Decrypt default config, in_data 8'hD5 -> 8'h00; 8'h2A -> 8'hFF. Random 256-byte round trip encrypt then decrypt returns the original.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored. out_ready=1 -> IDLE next cycle.
- Reset asserted mid-RUN (rnd=1) -> next cycle IDLE, out_valid 0, busy 0. The following byte 8'h00 still yields 8'hD5.
- (ENCRYPT_CFG_EN) Write perm identity 0..7, keys 8'h01/8'h02/8'h04, then commit in IDLE -> cfg_err 0. Encrypt 8'h00 -> 8'h07.
- (ENCRYPT_CFG_EN) Write perm[0]=perm[1]=3 and commit -> cfg_err 1, 8'h00 still encrypts with the previous set. Commit while busy -> ignored.

Source files
------------

// File: rtl/encrypt_ctrl.sv
// encrypt_ctrl: iterative XOR/permute byte cipher sequencer, one round per clock.
// Define ENCRYPT_CFG_EN to enable the runtime key/permutation configuration port.

`ifndef XOR_KEY1
`define XOR_KEY1 8'hDE
`endif
`ifndef XOR_KEY2
`define XOR_KEY2 8'hAD
`endif
`ifndef XOR_KEY3
`define XOR_KEY3 8'hBE
`endif
`ifndef PERM_0
`define PERM_0 3'd7
`endif
`ifndef PERM_1
`define PERM_1 3'd6
`endif
`ifndef PERM_2
`define PERM_2 3'd5
`endif
`ifndef PERM_3
`define PERM_3 3'd4
`endif
`ifndef PERM_4
`define PERM_4 3'd3
`endif
`ifndef PERM_5
`define PERM_5 3'd2
`endif
`ifndef PERM_6
`define PERM_6 3'd1
`endif
`ifndef PERM_7
`define PERM_7 3'd0
`endif

module encrypt_ctrl #(
    parameter logic [7:0] KEY1_RST = `XOR_KEY1,
    parameter logic [7:0] KEY2_RST = `XOR_KEY2,
    parameter logic [7:0] KEY3_RST = `XOR_KEY3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    input  logic       cfg_wr,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       cfg_commit,
    output logic       cfg_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Entry i of a permutation lives in bits [3*i +: 3].
    localparam logic [23:0] PERM_RST = {`PERM_7, `PERM_6, `PERM_5, `PERM_4,
                                        `PERM_3, `PERM_2, `PERM_1, `PERM_0};

    function automatic logic [7:0] permute(input logic [7:0] x, input logic [23:0] p);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = x[p[3*i +: 3]];
        return r;
    endfunction

    function automatic logic [7:0] permute_inv(input logic [7:0] x, input logic [23:0] p);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[p[3*i +: 3]] = x[i];
        return r;
    endfunction

    state_e      state_q;
    logic [7:0]  acc_q;
    logic [1:0]  rnd_q;
    logic        mode_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic [7:0]  key1, key2, key3;
    logic [23:0] perm;

`ifdef ENCRYPT_CFG_EN
    function automatic logic is_bijection(input logic [23:0] p);
        logic [7:0] seen;
        seen = '0;
        for (int i = 0; i < 8; i++) seen[p[3*i +: 3]] = 1'b1;
        return &seen;
    endfunction

    logic [7:0]  sh_key1_q, sh_key2_q, sh_key3_q;
    logic [7:0]  sh_key1_d, sh_key2_d, sh_key3_d;
    logic [23:0] sh_perm_q, sh_perm_d;
    logic [7:0]  act_key1_q, act_key2_q, act_key3_q;
    logic [23:0] act_perm_q;
    logic        cfg_err_q;
    logic        commit_take;

    // The write lands first so a same-cycle commit sees the updated shadow.
    always_comb begin
        sh_key1_d = sh_key1_q;
        sh_key2_d = sh_key2_q;
        sh_key3_d = sh_key3_q;
        sh_perm_d = sh_perm_q;
        if (cfg_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (cfg_addr == 4'(i)) sh_perm_d[3*i +: 3] = cfg_wdata[2:0];
            end
            if (cfg_addr == 4'd8)  sh_key1_d = cfg_wdata;
            if (cfg_addr == 4'd9)  sh_key2_d = cfg_wdata;
            if (cfg_addr == 4'd10) sh_key3_d = cfg_wdata;
        end
        commit_take = cfg_commit && (state_q == StIdle) && !in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_key1_q  <= KEY1_RST;
            sh_key2_q  <= KEY2_RST;
            sh_key3_q  <= KEY3_RST;
            sh_perm_q  <= PERM_RST;
            act_key1_q <= KEY1_RST;
            act_key2_q <= KEY2_RST;
            act_key3_q <= KEY3_RST;
            act_perm_q <= PERM_RST;
            cfg_err_q  <= 1'b0;
        end else begin
            sh_key1_q <= sh_key1_d;
            sh_key2_q <= sh_key2_d;
            sh_key3_q <= sh_key3_d;
            sh_perm_q <= sh_perm_d;
            if (commit_take) begin
                if (is_bijection(sh_perm_d)) begin
                    act_key1_q <= sh_key1_d;
                    act_key2_q <= sh_key2_d;
                    act_key3_q <= sh_key3_d;
                    act_perm_q <= sh_perm_d;
                    cfg_err_q  <= 1'b0;
                end else begin
                    cfg_err_q  <= 1'b1;
                end
            end
        end
    end

    assign key1    = act_key1_q;
    assign key2    = act_key2_q;
    assign key3    = act_key3_q;
    assign perm    = act_perm_q;
    assign cfg_err = cfg_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_wr, cfg_addr, cfg_wdata, cfg_commit};

    assign key1    = KEY1_RST;
    assign key2    = KEY2_RST;
    assign key3    = KEY3_RST;
    assign perm    = PERM_RST;
    assign cfg_err = 1'b0;
`endif

    logic [7:0] round_key;
    logic [7:0] mixed;
    logic [7:0] round_out;

    // Decrypt walks the keys in reverse and uses the inverse permutation.
    always_comb begin
        case (rnd_q)
            2'd0:    round_key = mode_q ? key3 : key1;
            2'd1:    round_key = key2;
            default: round_key = mode_q ? key1 : key3;
        endcase
        mixed = acc_q ^ round_key;
        if (rnd_q == 2'd2) begin
            round_out = mixed;
        end else begin
            round_out = mode_q ? permute_inv(mixed, perm) : permute(mixed, perm);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            rnd_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q      <= in_data;
                        mode_q     <= in_decrypt;
                        rnd_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    acc_q <= round_out;
                    if (rnd_q == 2'd2) begin
                        rnd_q       <= '0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 2'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule
